mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one single-port memory
//
// Purpose: serialises instruction-fetch and data requests onto one shared
// memory port. One transaction runs at a time. A read takes three cycles to
// its ready pulse and a write takes two. Fetch and data alternate when both
// are requesting. Every output is registered.
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   if_req/if_addr         fetch request (held until if_ready) and address
//   if_rdata/if_ready      fetched word and its one-cycle completion pulse
//   d_read/d_write         data request direction (held until d_ready)
//   d_addr/d_wdata         data address and write value
//   d_rdata/d_ready        read word and its one-cycle completion pulse
//   mem_addr/mem_wdata     shared memory address and write data
//   mem_read/mem_write     one-cycle memory strobes; never both high
//   mem_rdata              memory read data, valid the cycle after mem_read
//   busy                   high whenever a transaction is in flight
//   proto_err              sticky: d_read and d_write granted together
module mem_port_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_RD,
    S_WAIT_RD,
    S_ISSUE_WR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic last_data;   // 0 = fetch was granted last, 1 = data was
  logic gnt_data;    // requester owning the current transaction
  logic d_req, pick_any, pick_data, pick_write;
  logic mem_read_nxt, mem_write_nxt, if_ready_nxt, d_ready_nxt, busy_nxt;

  // Data normally wins. Fetch wins only if data took the previous grant,
  // so neither side can starve the other.
  always_comb begin
    d_req      = d_read | d_write;
    pick_any   = d_req | if_req;
    pick_data  = d_req & ~(last_data & if_req);
    pick_write = pick_data & d_write;   // read+write together is a write
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          state_nxt = pick_write ? S_ISSUE_WR : S_ISSUE_RD;
        end
      end
      S_ISSUE_RD: state_nxt = S_WAIT_RD;
      S_WAIT_RD:  state_nxt = S_DONE;
      S_ISSUE_WR: state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and then registered,
  // so each strobe is visible in the same cycle as its state.
  always_comb begin
    mem_read_nxt  = (state_nxt == S_ISSUE_RD);
    mem_write_nxt = (state_nxt == S_ISSUE_WR);
    busy_nxt      = (state_nxt != S_IDLE);
    if_ready_nxt  = (state_nxt == S_DONE) & ~gnt_data;
    d_ready_nxt   = (state_nxt == S_DONE) & gnt_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_data <= 1'b0;
      gnt_data  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
      busy      <= busy_nxt;
      // The memory-side address and data registers double as the grant
      // latches, so requester inputs are ignored after the grant.
      if (state == S_IDLE && pick_any) begin
        last_data <= pick_data;
        gnt_data  <= pick_data;
        mem_addr  <= pick_data ? d_addr : if_addr;
        if (pick_write) begin
          mem_wdata <= d_wdata;
        end
        if (pick_data && d_read && d_write) begin
          proto_err <= 1'b1;
        end
      end
      if (state == S_WAIT_RD) begin
        if (gnt_data) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
